mem_access_stage: RTL and testbench

- Memory-access stage of the 5-stage RV64 pipeline, between execute and writeback.
- Turns load/store micro-ops into data-cache requests using a valid/ready request channel and a valid-only response channel.
- Aligns and extends load data, and forwards ALU results untouched.
- Produces the writeback inputs: load data, ALU result, load/ALU select, destination register, ecall flag, PC.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_align.sv | 63 ++++++
 rtl/mem_access_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg: shared types and constants for the memory-access stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int XLEN    = 64;
  localparam int REGBITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// ============================================================================
// mem_align: store shift/strobe, load extract/extend, misalignment detect
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_align
  import mem_pkg::*;
#(
  parameter int XLEN = mem_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] lddata,
  output logic            misaligned
);

  logic [2:0]      w_off;
  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_shifted;
  logic            w_size_mis;
  logic            w_illegal;

  always_comb begin
    w_off     = addr[2:0];
    w_shamt   = {w_off, 3'b000};
    wdata     = store_data << w_shamt;
    w_shifted = rdata >> w_shamt;

    // funct3[1:0] encodes access size for both loads and stores
    wstrb      = 8'h00;
    w_size_mis = 1'b0;
    case (funct3[1:0])
      2'd0: begin wstrb = 8'h01 << w_off; w_size_mis = 1'b0;        end
      2'd1: begin wstrb = 8'h03 << w_off; w_size_mis = addr[0];     end
      2'd2: begin wstrb = 8'h0F << w_off; w_size_mis = |addr[1:0];  end
      default: begin wstrb = 8'hFF;       w_size_mis = |addr[2:0];  end
    endcase
    if (!is_store) wstrb = 8'h00;

    w_illegal  = (is_load && funct3 == 3'b111) || (is_store && funct3[2]);
    misaligned = (is_load || is_store) && (w_size_mis || w_illegal);

    case (funct3)
      F3_LB:   lddata = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_LH:   lddata = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   lddata = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      F3_LBU:  lddata = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      F3_LHU:  lddata = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      F3_LWU:  lddata = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: lddata = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage: RV64 memory-access pipeline stage (execute -> writeback)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_stage
  import mem_pkg::*;
#(
  parameter int XLEN    = mem_pkg::XLEN,
  parameter int REGBITS = mem_pkg::REGBITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_pc,
  input  logic [XLEN-1:0]    in_alures,
  input  logic [XLEN-1:0]    in_store_data,
  input  logic [2:0]         in_funct3,
  input  logic               in_is_load,
  input  logic               in_is_store,
  input  logic               in_is_ecall,
  input  logic [REGBITS-1:0] in_rd,
  input  logic               in_flush,
  output logic               dc_req_valid,
  input  logic               dc_req_ready,
  output logic [XLEN-1:0]    dc_req_addr,
  output logic               dc_req_we,
  output logic [XLEN-1:0]    dc_req_wdata,
  output logic [7:0]         dc_req_wstrb,
  input  logic               dc_resp_valid,
  input  logic [XLEN-1:0]    dc_resp_rdata,
  output logic               out_valid,
  output logic [31:0]        out_pc,
  output logic [XLEN-1:0]    out_lddata,
  output logic [XLEN-1:0]    out_alures,
  output logic               out_ld_or_alu,
  output logic [REGBITS-1:0] out_rd,
  output logic               out_is_ecall,
  output logic               out_misaligned
);

  mem_state_t state_q, state_d;

  logic [31:0]        pc_q, pc_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    sdata_q, sdata_d;
  logic [2:0]         f3_q, f3_d;
  logic               ld_q, ld_d;
  logic               st_q, st_d;
  logic               ec_q, ec_d;
  logic [REGBITS-1:0] rd_q, rd_d;

  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_pc_q, out_pc_d;
  logic [XLEN-1:0]    out_lddata_q, out_lddata_d;
  logic [XLEN-1:0]    out_alures_q, out_alures_d;
  logic               out_ld_or_alu_q, out_ld_or_alu_d;
  logic [REGBITS-1:0] out_rd_q, out_rd_d;
  logic               out_is_ecall_q, out_is_ecall_d;
  logic               out_misaligned_q, out_misaligned_d;

  logic               w_idle;
  logic [2:0]         w_f3;
  logic               w_ld;
  logic               w_st;
  logic [XLEN-1:0]    w_addr;
  logic [XLEN-1:0]    w_sdata;
  logic [XLEN-1:0]    w_wdata;
  logic [7:0]         w_wstrb;
  logic [XLEN-1:0]    w_lddata;
  logic               w_misaligned;

  // One aligner serves both phases: live inputs in IDLE, latched op otherwise
  assign w_idle  = (state_q == IDLE);
  assign w_f3    = w_idle ? in_funct3     : f3_q;
  assign w_ld    = w_idle ? in_is_load    : ld_q;
  assign w_st    = w_idle ? in_is_store   : st_q;
  assign w_addr  = w_idle ? in_alures     : addr_q;
  assign w_sdata = w_idle ? in_store_data : sdata_q;

  mem_align #(.XLEN(XLEN)) u_align (
    .funct3     (w_f3),
    .is_load    (w_ld),
    .is_store   (w_st),
    .addr       (w_addr),
    .store_data (w_sdata),
    .rdata      (dc_resp_rdata),
    .wdata      (w_wdata),
    .wstrb      (w_wstrb),
    .lddata     (w_lddata),
    .misaligned (w_misaligned)
  );

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    addr_d           = addr_q;
    sdata_d          = sdata_q;
    f3_d             = f3_q;
    ld_d             = ld_q;
    st_d             = st_q;
    ec_d             = ec_q;
    rd_d             = rd_q;
    out_valid_d      = 1'b0;
    out_pc_d         = out_pc_q;
    out_lddata_d     = out_lddata_q;
    out_alures_d     = out_alures_q;
    out_ld_or_alu_d  = out_ld_or_alu_q;
    out_rd_d         = out_rd_q;
    out_is_ecall_d   = out_is_ecall_q;
    out_misaligned_d = out_misaligned_q;

    case (state_q)
      IDLE: begin
        if (in_valid && !in_flush) begin
          if (!(in_is_load || in_is_store) || w_misaligned) begin
            out_valid_d      = 1'b1;
            out_pc_d         = in_pc;
            out_alures_d     = in_alures;
            out_ld_or_alu_d  = 1'b0;
            out_rd_d         = w_misaligned ? '0 : in_rd;
            out_is_ecall_d   = in_is_ecall;
            out_misaligned_d = w_misaligned;
          end else begin
            pc_d    = in_pc;
            addr_d  = in_alures;
            sdata_d = in_store_data;
            f3_d    = in_funct3;
            ld_d    = in_is_load;
            st_d    = in_is_store;
            ec_d    = in_is_ecall;
            rd_d    = in_rd;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A flush coinciding with the handshake still owes us a response
        if (in_flush) state_d = dc_req_ready ? DRAIN : IDLE;
        else if (dc_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (in_flush) begin
          state_d = dc_resp_valid ? IDLE : DRAIN;
        end else if (dc_resp_valid) begin
          out_valid_d      = 1'b1;
          out_pc_d         = pc_q;
          out_alures_d     = addr_q;
          out_lddata_d     = ld_q ? w_lddata : out_lddata_q;
          out_ld_or_alu_d  = ld_q;
          out_rd_d         = st_q ? '0 : rd_q;
          out_is_ecall_d   = ec_q;
          out_misaligned_d = 1'b0;
          state_d          = IDLE;
        end
      end
      DRAIN: begin
        if (dc_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      pc_q             <= '0;
      addr_q           <= '0;
      sdata_q          <= '0;
      f3_q             <= '0;
      ld_q             <= 1'b0;
      st_q             <= 1'b0;
      ec_q             <= 1'b0;
      rd_q             <= '0;
      out_valid_q      <= 1'b0;
      out_pc_q         <= '0;
      out_lddata_q     <= '0;
      out_alures_q     <= '0;
      out_ld_or_alu_q  <= 1'b0;
      out_rd_q         <= '0;
      out_is_ecall_q   <= 1'b0;
      out_misaligned_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      addr_q           <= addr_d;
      sdata_q          <= sdata_d;
      f3_q             <= f3_d;
      ld_q             <= ld_d;
      st_q             <= st_d;
      ec_q             <= ec_d;
      rd_q             <= rd_d;
      out_valid_q      <= out_valid_d;
      out_pc_q         <= out_pc_d;
      out_lddata_q     <= out_lddata_d;
      out_alures_q     <= out_alures_d;
      out_ld_or_alu_q  <= out_ld_or_alu_d;
      out_rd_q         <= out_rd_d;
      out_is_ecall_q   <= out_is_ecall_d;
      out_misaligned_q <= out_misaligned_d;
    end
  end

  assign in_ready       = w_idle;
  assign dc_req_valid   = (state_q == REQ);
  assign dc_req_addr    = {addr_q[XLEN-1:3], 3'b000};
  assign dc_req_we      = st_q;
  assign dc_req_wdata   = w_wdata;
  assign dc_req_wstrb   = w_wstrb;

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_lddata     = out_lddata_q;
  assign out_alures     = out_alures_q;
  assign out_ld_or_alu  = out_ld_or_alu_q;
  assign out_rd         = out_rd_q;
  assign out_is_ecall   = out_is_ecall_q;
  assign out_misaligned = out_misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage: directed self-checking bench for mem_access_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [63:0] in_alures;
  logic [63:0] in_store_data;
  logic [2:0]  in_funct3;
  logic        in_is_load;
  logic        in_is_store;
  logic        in_is_ecall;
  logic [4:0]  in_rd;
  logic        in_flush;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [63:0] dc_req_addr;
  logic        dc_req_we;
  logic [63:0] dc_req_wdata;
  logic [7:0]  dc_req_wstrb;
  logic        dc_resp_valid;
  logic [63:0] dc_resp_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [63:0] out_lddata;
  logic [63:0] out_alures;
  logic        out_ld_or_alu;
  logic [4:0]  out_rd;
  logic        out_is_ecall;
  logic        out_misaligned;

  int tests = 0;
  int fails = 0;

  mem_access_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_alures      (in_alures),
    .in_store_data  (in_store_data),
    .in_funct3      (in_funct3),
    .in_is_load     (in_is_load),
    .in_is_store    (in_is_store),
    .in_is_ecall    (in_is_ecall),
    .in_rd          (in_rd),
    .in_flush       (in_flush),
    .dc_req_valid   (dc_req_valid),
    .dc_req_ready   (dc_req_ready),
    .dc_req_addr    (dc_req_addr),
    .dc_req_we      (dc_req_we),
    .dc_req_wdata   (dc_req_wdata),
    .dc_req_wstrb   (dc_req_wstrb),
    .dc_resp_valid  (dc_resp_valid),
    .dc_resp_rdata  (dc_resp_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_lddata     (out_lddata),
    .out_alures     (out_alures),
    .out_ld_or_alu  (out_ld_or_alu),
    .out_rd         (out_rd),
    .out_is_ecall   (out_is_ecall),
    .out_misaligned (out_misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [63:0] alu, input logic [63:0] sd,
                       input logic [2:0] f3, input logic ld, input logic st,
                       input logic ec, input logic [4:0] rd);
    in_valid      = 1'b1;
    in_pc         = pc;
    in_alures     = alu;
    in_store_data = sd;
    in_funct3     = f3;
    in_is_load    = ld;
    in_is_store   = st;
    in_is_ecall   = ec;
    in_rd         = rd;
    tick();
    in_valid      = 1'b0;
    in_is_load    = 1'b0;
    in_is_store   = 1'b0;
    in_is_ecall   = 1'b0;
  endtask

  // From REQ: handshake, then deliver one response and step past the retire edge
  task automatic finish(input logic [63:0] rdata);
    dc_req_ready  = 1'b1;
    tick();
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b1;
    dc_resp_rdata = rdata;
    tick();
    dc_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_alures = '0; in_store_data = '0;
    in_funct3 = '0; in_is_load = 1'b0; in_is_store = 1'b0; in_is_ecall = 1'b0;
    in_rd = '0; in_flush = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
    dc_resp_rdata = '0;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req_valid", 64'(dc_req_valid), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_out_lddata", out_lddata, 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    rst = 1'b0;
    tick();

    // ALU op passthrough
    issue(32'h100, 64'h1234, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd5);
    chk("alu_valid", 64'(out_valid), 64'd1);
    chk("alu_res", out_alures, 64'h1234);
    chk("alu_rd", 64'(out_rd), 64'd5);
    chk("alu_sel", 64'(out_ld_or_alu), 64'd0);
    chk("alu_pc", 64'(out_pc), 64'h100);
    chk("alu_noreq", 64'(dc_req_valid), 64'd0);
    tick();
    chk("alu_pulse", 64'(out_valid), 64'd0);

    // LB at 0x1003, response two cycles after request
    issue(32'h104, 64'h1003, 64'h0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd7);
    chk("lb_req_valid", 64'(dc_req_valid), 64'd1);
    chk("lb_ready0", 64'(in_ready), 64'd0);
    chk("lb_addr", dc_req_addr, 64'h1000);
    chk("lb_we", 64'(dc_req_we), 64'd0);
    chk("lb_wstrb", 64'(dc_req_wstrb), 64'd0);
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    chk("lb_wait_reqv", 64'(dc_req_valid), 64'd0);
    chk("lb_wait_ready", 64'(in_ready), 64'd0);
    tick();
    chk("lb_wait_noout", 64'(out_valid), 64'd0);
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 64'h0000_0000_8000_0000;
    tick();
    dc_resp_valid = 1'b0;
    chk("lb_valid", 64'(out_valid), 64'd1);
    chk("lb_data", out_lddata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_sel", 64'(out_ld_or_alu), 64'd1);
    chk("lb_rd", 64'(out_rd), 64'd7);
    chk("lb_pc", 64'(out_pc), 64'h104);
    chk("lb_ready1", 64'(in_ready), 64'd1);

    // SH at 0x2006
    issue(32'h108, 64'h2006, 64'hBEEF, 3'b001, 1'b0, 1'b1, 1'b0, 5'd9);
    chk("sh_addr", dc_req_addr, 64'h2000);
    chk("sh_wstrb", 64'(dc_req_wstrb), 64'hC0);
    chk("sh_wdata", dc_req_wdata, 64'hBEEF_0000_0000_0000);
    chk("sh_we", 64'(dc_req_we), 64'd1);
    finish(64'h0);
    chk("sh_valid", 64'(out_valid), 64'd1);
    chk("sh_rd", 64'(out_rd), 64'd0);
    chk("sh_sel", 64'(out_ld_or_alu), 64'd0);

    // SB at 0x2005 and SD at 0x2008
    issue(32'h10C, 64'h2005, 64'h11AA, 3'b000, 1'b0, 1'b1, 1'b0, 5'd1);
    chk("sb_wstrb", 64'(dc_req_wstrb), 64'h20);
    chk("sb_wdata", dc_req_wdata, 64'h0011_AA00_0000_0000);
    finish(64'h0);
    issue(32'h110, 64'h2008, 64'h0123_4567_89AB_CDEF, 3'b011, 1'b0, 1'b1, 1'b0, 5'd1);
    chk("sd_wstrb", 64'(dc_req_wstrb), 64'hFF);
    chk("sd_wdata", dc_req_wdata, 64'h0123_4567_89AB_CDEF);
    chk("sd_addr", dc_req_addr, 64'h2008);
    finish(64'h0);

    // LW misaligned: no request, flagged retire
    issue(32'h114, 64'h3002, 64'h0, 3'b010, 1'b1, 1'b0, 1'b0, 5'd3);
    chk("mis_valid", 64'(out_valid), 64'd1);
    chk("mis_flag", 64'(out_misaligned), 64'd1);
    chk("mis_rd", 64'(out_rd), 64'd0);
    chk("mis_noreq", 64'(dc_req_valid), 64'd0);
    chk("mis_ready", 64'(in_ready), 64'd1);
    tick();
    chk("mis_pulse", 64'(out_valid), 64'd0);

    // Store with funct3=100 is illegal
    issue(32'h118, 64'h3000, 64'h0, 3'b100, 1'b0, 1'b1, 1'b0, 5'd3);
    chk("ill_st_flag", 64'(out_misaligned), 64'd1);
    chk("ill_st_noreq", 64'(dc_req_valid), 64'd0);

    // LHU and LW sign-extension
    issue(32'h11C, 64'h6006, 64'h0, 3'b101, 1'b1, 1'b0, 1'b0, 5'd10);
    finish(64'hABCD_0000_0000_0000);
    chk("lhu_data", out_lddata, 64'h0000_0000_0000_ABCD);
    chk("lhu_misflag", 64'(out_misaligned), 64'd0);
    issue(32'h120, 64'h7004, 64'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd11);
    finish(64'h8765_4321_0000_0000);
    chk("lw_data", out_lddata, 64'hFFFF_FFFF_8765_4321);
    chk("lw_ecall", 64'(out_is_ecall), 64'd1);
    chk("lw_rd", 64'(out_rd), 64'd11);

    // Flush in IDLE beats in_valid
    in_flush = 1'b1;
    issue(32'h124, 64'h55, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd2);
    in_flush = 1'b0;
    chk("idle_flush_noout", 64'(out_valid), 64'd0);

    // LD stalled by cache, flushed before handshake
    issue(32'h128, 64'h4008, 64'h0, 3'b011, 1'b1, 1'b0, 1'b0, 5'd4);
    chk("ldst_reqv1", 64'(dc_req_valid), 64'd1);
    tick();
    chk("ldst_addr2", dc_req_addr, 64'h4008);
    chk("ldst_reqv2", 64'(dc_req_valid), 64'd1);
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    chk("ldst_drop", 64'(dc_req_valid), 64'd0);
    chk("ldst_noout", 64'(out_valid), 64'd0);
    chk("ldst_ready", 64'(in_ready), 64'd1);
    tick();
    chk("ldst_noout2", 64'(out_valid), 64'd0);

    // LD accepted, flushed in WAIT, late response drained
    issue(32'h12C, 64'h5000, 64'h0, 3'b011, 1'b1, 1'b0, 1'b0, 5'd6);
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    chk("drn_ready0", 64'(in_ready), 64'd0);
    tick();
    tick();
    chk("drn_ready0b", 64'(in_ready), 64'd0);
    chk("drn_noout", 64'(out_valid), 64'd0);
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 64'hDEAD_BEEF;
    tick();
    dc_resp_valid = 1'b0;
    chk("drn_noout2", 64'(out_valid), 64'd0);
    chk("drn_ready1", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
